// File: rtl/mdu_sequencer_if.sv
// Request/grant/strobe bundle between the two requesters, the mult/div unit and mdu_sequencer.
// master = requester/unit side, slave = sequencer side.
interface mdu_sequencer_if;
  localparam int unsigned CNT_W = 6;

  logic             req_a;
  logic             op_a;
  logic             flush_a;
  logic             req_b;
  logic             op_b;
  logic             flush_b;
  logic             div_zero;

  logic             grant_a;
  logic             grant_b;
  logic             unit_load;
  logic             unit_step;
  logic             unit_op;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done_a;
  logic             done_b;
  logic             exc;

  modport master (
    output req_a, op_a, flush_a, req_b, op_b, flush_b, div_zero,
    input  grant_a, grant_b, unit_load, unit_step, unit_op, count, busy, done_a, done_b, exc
  );

  modport slave (
    input  req_a, op_a, flush_a, req_b, op_b, flush_b, div_zero,
    output grant_a, grant_b, unit_load, unit_step, unit_op, count, busy, done_a, done_b, exc
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Round-robin owner of the 34-step mult/div unit: LOAD, RUN x32, DONE, with flush abort and
// divide-by-zero early exit. Every output is decoded from registered state only.
module mdu_sequencer #(
  parameter int unsigned COUNT_LAST = 33,
  parameter int unsigned RUN_STEPS  = 32
) (
  input  logic         clock,
  input  logic         reset,
  mdu_sequencer_if.slave bus
);
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state,   w_state_nx;
  logic [CNT_W-1:0] r_count,   w_count_nx;
  logic             r_owner_b, w_owner_b_nx;
  logic             r_op,      w_op_nx;
  logic             r_exc,     w_exc_nx;
  logic             r_last_b,  w_last_b_nx;

  logic w_elig_a;
  logic w_elig_b;
  logic w_flush_own;

  assign w_elig_a    = bus.req_a & ~bus.flush_a;
  assign w_elig_b    = bus.req_b & ~bus.flush_b;
  assign w_flush_own = r_owner_b ? bus.flush_b : bus.flush_a;

  // State register; r_last_b resets to 1 so A wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_owner_b <= 1'b0;
      r_op      <= 1'b0;
      r_exc     <= 1'b0;
      r_last_b  <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_count   <= w_count_nx;
      r_owner_b <= w_owner_b_nx;
      r_op      <= w_op_nx;
      r_exc     <= w_exc_nx;
      r_last_b  <= w_last_b_nx;
    end
  end

  // Next-state: arbitration in IDLE, step sequencing, abort on owner flush.
  always_comb begin
    w_state_nx   = r_state;
    w_count_nx   = r_count;
    w_owner_b_nx = r_owner_b;
    w_op_nx      = r_op;
    w_exc_nx     = r_exc;
    w_last_b_nx  = r_last_b;

    case (r_state)
      S_IDLE: begin
        w_count_nx = '0;
        w_exc_nx   = 1'b0;
        w_op_nx    = 1'b0;
        if (w_elig_a && (!w_elig_b || r_last_b)) begin
          w_owner_b_nx = 1'b0;
          w_op_nx      = bus.op_a;
          w_state_nx   = S_LOAD;
        end else if (w_elig_b) begin
          w_owner_b_nx = 1'b1;
          w_op_nx      = bus.op_b;
          w_state_nx   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_flush_own) begin
          w_state_nx  = S_IDLE;
          w_count_nx  = '0;
          w_exc_nx    = 1'b0;
          w_op_nx     = 1'b0;
          w_last_b_nx = r_owner_b;
        end else if (r_op && bus.div_zero) begin
          w_state_nx = S_DONE;
          w_count_nx = CNT_W'(COUNT_LAST);
          w_exc_nx   = 1'b1;
        end else begin
          w_state_nx = S_RUN;
          w_count_nx = CNT_W'(1);
        end
      end
      S_RUN: begin
        if (w_flush_own) begin
          w_state_nx  = S_IDLE;
          w_count_nx  = '0;
          w_exc_nx    = 1'b0;
          w_op_nx     = 1'b0;
          w_last_b_nx = r_owner_b;
        end else if (r_count >= CNT_W'(RUN_STEPS)) begin
          w_state_nx = S_DONE;
          w_count_nx = CNT_W'(COUNT_LAST);
        end else begin
          w_count_nx = r_count + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nx  = S_IDLE;
        w_count_nx  = '0;
        w_exc_nx    = 1'b0;
        w_op_nx     = 1'b0;
        w_last_b_nx = r_owner_b;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_count_nx = '0;
      end
    endcase

    // An out-of-range count can only come from corruption; recover to idle.
    if (r_count > CNT_W'(COUNT_LAST)) begin
      w_state_nx = S_IDLE;
      w_count_nx = '0;
      w_exc_nx   = 1'b0;
      w_op_nx    = 1'b0;
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.grant_a   = (r_state != S_IDLE) & ~r_owner_b;
  assign bus.grant_b   = (r_state != S_IDLE) &  r_owner_b;
  assign bus.unit_load = (r_state == S_LOAD);
  assign bus.unit_step = (r_state == S_RUN);
  assign bus.unit_op   = r_op;
  assign bus.count     = r_count;
  assign bus.done_a    = (r_state == S_DONE) & ~r_owner_b;
  assign bus.done_b    = (r_state == S_DONE) &  r_owner_b;
  assign bus.exc       = r_exc;

endmodule
